// File: rtl/pulse_decode_pkg.sv
// Shared types and constants for the sequenced 2-to-4 pulse decoder.
// Holds the FSM state encoding, channel code names and the counter width helper.
package pulse_decode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  // Counter must hold the larger of the two reload values without wrapping.
  function automatic int cnt_width(input int pulse_len, input int gap_len);
    int m;
    m = (pulse_len > gap_len) ? pulse_len : gap_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dec24_onehot.sv
// Purely combinational 2-bit channel code to 4-bit one-hot decoder.
module dec24_onehot
  import pulse_decode_pkg::*;
(
  input  logic [1:0] a,
  output logic [3:0] d
);

  always_comb begin
    d = 4'b0000;
    case (a)
      CH0: d = 4'b0001;
      CH1: d = 4'b0010;
      CH2: d = 4'b0100;
      CH3: d = 4'b1000;
      default: d = 4'b0000;
    endcase
  end

endmodule

// File: rtl/pulse_decode24.sv
// Sequenced 2-to-4 decoder: accepts a code, drives its one-hot strobe for
// PULSE_LEN cycles, then holds all lines low for GAP_LEN guard cycles.
module pulse_decode24
  import pulse_decode_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] a,
  output logic [3:0] d,
  output logic       busy,
  output logic       done
);

  localparam int CW = cnt_width(PULSE_LEN, GAP_LEN);
  localparam logic [CW-1:0] PULSE_INIT = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_INIT   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      d_reg, d_next;
  logic [3:0]      dec_d;
  logic            accept;

  dec24_onehot u_dec (
    .a (a),
    .d (dec_d)
  );

  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          d_next     = dec_d;
          cnt_next   = PULSE_INIT;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          d_next = 4'b0000;
          // With no guard gap the IDLE acceptance cycle is the only zero cycle.
          if (GAP_LEN > 0) begin
            state_next = GAP;
            cnt_next   = GAP_INIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        d_next     = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      d_reg     <= 4'b0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
    end
  end

  assign d    = d_reg;
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == ACTIVE) && (cnt_reg == '0);

endmodule
